// File: rtl/max7219_chain_settings.sv
// Sequencer for a chain of NUM_DEVICES MAX7219s: expands a config broadcast or digit write into (addr,data) frames.
// Optional `MAX7219_CHAIN_BROADCAST_EN adds i_broadcast so a digit write lands on every device.
module max7219_chain_settings #(
  parameter int NUM_DEVICES = 4,
  parameter int DEV_W       = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stb,
  output logic             o_busy,
  output logic             o_ack,
  input  logic [DEV_W-1:0] i_device,
  input  logic [2:0]       i_digit,
  input  logic [7:0]       i_segment,
  input  logic             i_write_config,
  input  logic [7:0]       i_decode_mode,
  input  logic [3:0]       i_intensity,
  input  logic [2:0]       i_scan_limit,
  input  logic             i_enable,
  input  logic             i_display_test,
`ifdef MAX7219_CHAIN_BROADCAST_EN
  input  logic             i_broadcast,
`endif
  input  logic             i_next,
  output logic             o_write,
  output logic             o_last,
  output logic [3:0]       o_addr,
  output logic [7:0]       o_data
);

  localparam logic [DEV_W-1:0] LAST_DEV = DEV_W'(NUM_DEVICES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, ADVANCE, DONE} state_t;

  state_t           state;
  logic [DEV_W-1:0] dev_cnt;
  logic [2:0]       reg_idx;
  logic             cfg_q;
  logic [DEV_W-1:0] dev_q;
  logic [2:0]       digit_q;
  logic [7:0]       seg_q;
  logic [7:0]       dec_q;
  logic [3:0]       int_q;
  logic [2:0]       scan_q;
  logic             en_q;
  logic             test_q;
  logic             bcast_q;
  logic [3:0]       word_addr;
  logic [7:0]       word_data;
  logic             last_reg;

`ifdef MAX7219_CHAIN_BROADCAST_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)
      bcast_q <= 1'b0;
    else if ((state == IDLE || state == DONE) && i_stb)
      bcast_q <= i_broadcast;
  end
`else
  assign bcast_q = 1'b0;
`endif

  // An out-of-range i_device never matches the counter, so that frame is all NOOPs.
  always_comb begin
    word_addr = 4'h0;
    word_data = 8'h00;
    if (cfg_q) begin
      case (reg_idx)
        3'd0:    begin word_addr = 4'h9; word_data = dec_q;            end
        3'd1:    begin word_addr = 4'hA; word_data = {4'h0, int_q};    end
        3'd2:    begin word_addr = 4'hB; word_data = {5'h00, scan_q};  end
        3'd3:    begin word_addr = 4'hC; word_data = {7'h00, en_q};    end
        default: begin word_addr = 4'hF; word_data = {7'h00, test_q};  end
      endcase
    end else if (bcast_q || (dev_cnt == dev_q)) begin
      word_addr = {1'b0, digit_q} + 4'd1;
      word_data = seg_q;
    end
  end

  assign last_reg = cfg_q ? (reg_idx == 3'd4) : 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      o_busy  <= 1'b0;
      o_ack   <= 1'b0;
      o_write <= 1'b0;
      o_last  <= 1'b0;
      o_addr  <= 4'h0;
      o_data  <= 8'h00;
      dev_cnt <= '0;
      reg_idx <= 3'd0;
      cfg_q   <= 1'b0;
      dev_q   <= '0;
      digit_q <= 3'd0;
      seg_q   <= 8'h00;
      dec_q   <= 8'h00;
      int_q   <= 4'h0;
      scan_q  <= 3'd0;
      en_q    <= 1'b0;
      test_q  <= 1'b0;
    end else begin
      o_ack <= 1'b0;
      case (state)
        // DONE already shows o_busy=0, so a strobe there is accepted like in IDLE.
        IDLE, DONE: begin
          if (i_stb) begin
            cfg_q   <= i_write_config;
            dev_q   <= i_device;
            digit_q <= i_digit;
            seg_q   <= i_segment;
            dec_q   <= i_decode_mode;
            int_q   <= i_intensity;
            scan_q  <= i_scan_limit;
            en_q    <= i_enable;
            test_q  <= i_display_test;
            dev_cnt <= LAST_DEV;
            reg_idx <= 3'd0;
            o_busy  <= 1'b1;
            state   <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          o_addr  <= word_addr;
          o_data  <= word_data;
          o_last  <= (dev_cnt == '0);
          o_write <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          if (i_next) begin
            o_write <= 1'b0;
            state   <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (dev_cnt != '0) begin
            dev_cnt <= dev_cnt - DEV_W'(1);
            state   <= SETUP;
          end else begin
            dev_cnt <= LAST_DEV;
            if (last_reg) begin
              o_ack  <= 1'b1;
              o_busy <= 1'b0;
              state  <= DONE;
            end else begin
              reg_idx <= reg_idx + 3'd1;
              state   <= SETUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
